// File: rtl/iir_pkg.sv
// Shared constants and width helpers for the IIR sample driver slice.
package iir_pkg;

  localparam int DATA_W    = 22;
  localparam int FRAC_LEN  = 14;  // sfix22_En14 fractional bits
  localparam int DIV_RATIO = 3;

  // Occupancy must represent FIFO_DEPTH itself, hence the extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int phase_w(input int div_ratio);
    return (div_ratio < 2) ? 1 : $clog2(div_ratio);
  endfunction

endpackage

// File: rtl/iir_sample_driver_if.sv
// Valid/ready sample stream feeding the IIR sample driver.
interface iir_sample_driver_if #(
  parameter int DATA_W = 22
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/iir_sample_fifo.sv
// Synchronous FIFO with exact level output and synchronous flush.
module iir_sample_fifo
  import iir_pkg::*;
#(
  parameter int DATA_W = iir_pkg::DATA_W,
  parameter int DEPTH  = 4,
  localparam int LEVEL_W = level_w(DEPTH),
  localparam int PTR_W   = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  head,
  output logic [LEVEL_W-1:0] level,
  output logic               empty,
  output logic               full
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  assign empty = (level == '0);
  assign full  = (level == LEVEL_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; the level counter
  // alone decides which entries are valid, and unreset RAM maps to memories.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/iir_sample_driver.sv
// Fixed-rate sample driver: buffers a bursty stream and emits one sample per
// enb_1_3_0 strobe, zero-stuffing and counting underruns.
module iir_sample_driver
  import iir_pkg::*;
#(
  parameter int DATA_W     = iir_pkg::DATA_W,
  parameter int DIV_RATIO  = iir_pkg::DIV_RATIO,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          run,
  iir_sample_driver_if.slave            s,
  output logic                          enb_1_3_0,
  output logic [DATA_W-1:0]             sample_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [CNT_W-1:0]              underrun_cnt
);

  localparam int LEVEL_W = level_w(FIFO_DEPTH);
  localparam int PHASE_W = phase_w(DIV_RATIO);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DIV_RATIO - 1);

  logic [PHASE_W-1:0] phase;
  logic [LEVEL_W-1:0] level;
  logic [DATA_W-1:0]  head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               strobe_edge;
  logic               push;
  logic               pop;

  // The strobe is registered, so it is decided one phase ahead: the edge
  // that leaves LAST_PHASE is the edge that raises enb_1_3_0 and pops.
  assign strobe_edge = run && (phase == LAST_PHASE);
  assign s.s_ready   = !fifo_full && !clear;
  assign push        = s.s_valid && s.s_ready;
  assign pop         = strobe_edge && !fifo_empty;
  assign fifo_level  = level;

  iir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (s.s_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase        <= LAST_PHASE;
      enb_1_3_0    <= 1'b0;
      sample_out   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else if (clear) begin
      phase        <= LAST_PHASE;
      enb_1_3_0    <= 1'b0;
      sample_out   <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (run) phase <= (phase == LAST_PHASE) ? '0 : phase + PHASE_W'(1);
      enb_1_3_0 <= strobe_edge;
      if (strobe_edge) begin
        if (fifo_empty) begin
          // Empty at the strobe edge: a same-edge push is not bypassed.
          sample_out <= '0;
          underrun   <= 1'b1;
          if (underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
        end else begin
          sample_out <= head;
        end
      end
    end
  end

endmodule

// File: tb/tb_iir_sample_driver.sv
// Randomised and directed bench for iir_sample_driver against a queue model.
module tb_iir_sample_driver;

  localparam int DATA_W  = 22;
  localparam int DIV     = 3;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 10;  // narrowed so saturation is reachable quickly
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              clear = 1'b0;
  logic              run   = 1'b0;
  logic              valid = 1'b0;
  logic [DATA_W-1:0] data  = '0;

  logic              enb;
  logic [DATA_W-1:0] sample_out;
  logic [2:0]        fifo_level;
  logic              underrun;
  logic [CNT_W-1:0]  underrun_cnt;

  iir_sample_driver_if #(.DATA_W(DATA_W)) sif ();
  assign sif.s_valid = valid;
  assign sif.s_data  = data;

  iir_sample_driver #(
    .DATA_W     (DATA_W),
    .DIV_RATIO  (DIV),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .run          (run),
    .s            (sif),
    .enb_1_3_0    (enb),
    .sample_out   (sample_out),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: buffered samples, number of run-qualified edges since the
  // last reset/clear, and the expected registered outputs.
  logic [DATA_W-1:0] q[$];
  int                run_edges;
  logic              m_enb;
  logic [DATA_W-1:0] m_out;
  logic              m_und;
  int                m_cnt;
  bit                last_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    run_edges = 0;
    m_enb     = 1'b0;
    m_out     = '0;
    m_und     = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic compare_outputs();
    check("enb", enb, m_enb);
    check("sample_out", sample_out, m_out);
    check("fifo_level", fifo_level, q.size());
    check("underrun", underrun, m_und);
    check("underrun_cnt", underrun_cnt, m_cnt);
  endtask

  // One clock: check ready, advance the model with the held inputs, then
  // compare registered outputs shortly after the edge.
  task automatic cycle();
    bit exp_ready;
    bit strobe;
    #1;
    exp_ready = (q.size() != DEPTH) && !clear;
    check("s_ready", sif.s_ready, exp_ready);
    last_acc = valid && exp_ready && reset;
    if (!reset || clear) begin
      model_reset();
    end else begin
      strobe = run && (run_edges % DIV == 0);
      if (strobe) begin
        if (q.size() > 0) begin
          m_out = q.pop_front();
        end else begin
          m_out = '0;
          m_und = 1'b1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end
      end
      if (valid && exp_ready) q.push_back(data);
      m_enb = strobe;
      if (run) run_edges++;
    end
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic push_value(input logic [DATA_W-1:0] v);
    valid = 1'b1;
    data  = v;
    cycle();
    valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    int expected_seq;
    int popped;
    logic [DATA_W-1:0] next_val;

    model_reset();
    #12;
    compare_outputs();
    check("s_ready_in_reset", sif.s_ready, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Free-running with no input: strobes on edges 1, 4, 7 all underrun.
    run = 1'b1;
    repeat (9) cycle();
    check("idle_cnt", underrun_cnt, 3);
    check("idle_underrun", underrun, 1'b1);

    // Three samples preloaded, then drained in order.
    run = 1'b0;
    do_clear();
    push_value(22'h000400);
    push_value(22'h3FFC00);
    push_value(22'h1FFFFF);
    check("preload_level", fifo_level, 3);
    run = 1'b1;
    cycle();
    check("drain0", sample_out, 22'h000400);
    repeat (3) cycle();
    check("drain1", sample_out, 22'h3FFC00);
    repeat (3) cycle();
    check("drain2", sample_out, 22'h1FFFFF);
    check("drain2_no_underrun", underrun, 1'b0);
    repeat (3) cycle();
    check("drain3_zero", sample_out, 0);
    check("drain3_cnt", underrun_cnt, 1);

    // Clear with data buffered and underrun set; strobe resumes right after.
    run = 1'b0;
    push_value(22'h012345);
    push_value(22'h054321);
    push_value(22'h0ABCDE);
    check("pre_clear_level", fifo_level, 3);
    do_clear();
    check("clear_level", fifo_level, 0);
    check("clear_underrun", underrun, 1'b0);
    run = 1'b1;
    cycle();
    check("strobe_after_clear", enb, 1'b1);

    // Continuous producer: fill to full with run low, then stream 20 samples.
    run = 1'b0;
    do_clear();
    next_val = 1;
    valid    = 1'b1;
    repeat (6) begin
      data = next_val;
      cycle();
      if (last_acc) next_val++;
    end
    #1;
    check("full_level", fifo_level, 4);
    check("full_ready", sif.s_ready, 1'b0);
    run          = 1'b1;
    expected_seq = 1;
    popped       = 0;
    repeat (70) begin
      valid = (next_val <= 20);
      data  = next_val;
      cycle();
      if (last_acc) next_val++;
      if (enb && expected_seq <= 20) begin
        check("stream_seq", sample_out, expected_seq);
        expected_seq++;
        popped++;
      end
    end
    valid = 1'b0;
    check("stream_count", popped, 20);

    // Push on the strobe edge into an empty FIFO: not bypassed.
    run = 1'b0;
    do_clear();
    run   = 1'b1;
    valid = 1'b1;
    data  = 22'h2AAAA5;
    cycle();
    valid = 1'b0;
    check("bypass_zero", sample_out, 0);
    check("bypass_cnt", underrun_cnt, 1);
    repeat (3) cycle();
    check("bypass_next", sample_out, 22'h2AAAA5);

    // Randomised traffic, run gating and occasional clears.
    repeat (800) begin
      clear = ($urandom_range(0, 99) == 0);
      run   = ($urandom_range(0, 9) != 0);
      valid = $urandom_range(0, 1);
      data  = DATA_W'($urandom);
      cycle();
    end
    clear = 1'b0;

    // Asynchronous reset between edges mid-stream.
    run   = 1'b1;
    valid = 1'b1;
    repeat (4) begin
      data = DATA_W'($urandom);
      cycle();
    end
    #3;
    reset = 1'b0;
    #1;
    check("areset_enb", enb, 1'b0);
    check("areset_out", sample_out, 0);
    check("areset_level", fifo_level, 0);
    check("areset_underrun", underrun, 1'b0);
    check("areset_cnt", underrun_cnt, 0);
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
    valid = 1'b0;
    cycle();
    check("areset_first_strobe", enb, 1'b1);
    repeat (5) cycle();

    // Underrun counter saturation.
    do_clear();
    run = 1'b1;
    repeat ((CNT_MAX + 2) * DIV) cycle();
    check("cnt_saturated", underrun_cnt, CNT_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
